mips_bus_ram: RTL
=================

Name: mips_bus_ram

Overview:
- Parametrised two-region memory slave for the mips_cpu_bus Avalon-style port.
- Replaces the flat byte array in CPU testbenches.
- Data region is mapped at DATA_BASE; instruction region is mapped at INSTR_BASE (reset vector 0xBFC00000).
- Adds configurable waitrequest stalls, byteenable-masked reads, a registered read-valid pulse, and sticky error and transaction counters.

Parameters:
- DATA_BASE, 32'h0000_0000, byte address of data region word 0.
- DATA_WORDS, 64, data region depth in 32-bit words.
- INSTR_BASE, 32'hBFC0_0000, byte address of instruction region word 0.
- INSTR_WORDS, 256, instruction region depth in words.
- WAIT_CYCLES, 0, stall cycles inserted before each transfer is accepted (0..15).
- DATA_INIT, "", hex file loaded into the data region at time 0 (empty string: all zeros).
- INSTR_INIT, "", hex file loaded into the instruction region at time 0 (empty string: all zeros).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- address  in  32  byte address, word aligned
- read  in  1  read request
- write  in  1  write request
- byteenable  in  4  lane enables; bit n selects bits [8n+7:8n]
- writedata  in  32  write data, little-endian lanes
- waitrequest  out  1  stall; master holds all inputs stable while high
- readdata  out  32  read result
- readdatavalid  out  1  one-cycle pulse: readdata updated
- bus_error  out  1  sticky illegal-access flag
- err_address  out  32  address of the first illegal access
- n_reads  out  32  accepted legal reads
- n_writes  out  32  accepted legal writes

Behaviour:
- Reset (async, asserted): stall counter=0, readdata=0, readdatavalid=0, bus_error=0, err_address=0, n_reads=0, n_writes=0.
- Memory contents are not cleared by reset.
- req = read|write.
- waitrequest = req && (cnt != WAIT_CYCLES), combinational.
- States:
  - IDLE: cnt=0. A req with WAIT_CYCLES>0 moves to STALL with cnt=1.
  - STALL: cnt increments each cycle the request is held.
  - Acceptance: at the clk edge where req=1 and waitrequest=0, the transfer executes, cnt returns to 0, and the state returns to IDLE.
  - WAIT_CYCLES=0: waitrequest is never asserted; single-cycle accept.
- req dropped during STALL: cnt returns to 0, no transfer executes, no error is flagged.
- Address decode:
  - word index = (address-BASE)>>2 for the region where BASE <= address < BASE+4*WORDS.
  - Decoding is exact; no aliasing.
- Accepted legal read:
  - readdata lane n = mem lane n if byteenable[n], else 8'h00.
  - readdata and readdatavalid=1 register at the accept edge, i.e. valid the cycle after acceptance.
  - readdatavalid is high for exactly one cycle.
  - readdata holds its value until the next accepted read.
  - n_reads++.
- Accepted legal write: each lane with byteenable[n]=1 is written at the accept edge; other lanes are unchanged; n_writes++.
- A write followed immediately by a read of the same word returns the new data.
- Illegal access: any of
  - address[1:0]!=0
  - address unmapped
  - read&write both high
  - byteenable==0
- Illegal access response:
  - No memory change, no counter change, readdatavalid stays low.
  - It is still stalled WAIT_CYCLES and accepted normally.
  - bus_error goes to 1 and stays set until reset.
  - err_address captures the address only if bus_error was 0.
- Counters wrap modulo 2^32.
- Reset asserted mid-STALL or at an accept edge: the transfer is abandoned (no write, no valid pulse); the state returns to IDLE immediately.

Optional Feature:
BUS_RAM_RANDOM_WAIT_EN
- Defined: each transfer's stall length is lfsr[3:0] & WAIT_CYCLES instead of WAIT_CYCLES.
  - lfsr is a 16-bit Fibonacci LFSR with taps 16,14,13,11.
  - It is reset to 16'hACE1.
  - It advances once per accepted transfer.
  - This exercises variable CPU stall tolerance; all other behaviour is unchanged.
- Undefined: fixed stall of WAIT_CYCLES, no LFSR logic.

Test Plan:
1. WAIT_CYCLES=0, write 0xDEADBEEF be=4'hF to 0x10, then read 0x10 -> waitrequest never high; readdata=0xDEADBEEF with readdatavalid one cycle after the read accept; n_writes=1, n_reads=1.
2. Write be=4'b0101 data 0x11223344 over 0xFFFFFFFF at 0x20, read be=4'hF -> 0xFF22FF44. Read be=4'b0011 -> 0x0000FF44.
3. WAIT_CYCLES=3, read at 0xBFC00004 with INSTR_INIT word1=0x24020005 -> waitrequest high exactly 3 cycles; readdata=0x24020005 the cycle after accept.
4. Read 0x00000102 (misaligned), then 0x80000000 (unmapped) -> bus_error=1, err_address=0x00000102, no readdatavalid, counters unchanged.
5. WAIT_CYCLES=4: assert write, raise reset after 2 stall cycles, then check the target word -> contents unchanged, all outputs at reset values, next transfer stalls a full 4 cycles.
6. Read and write asserted together at 0x0 -> no write, bus_error=1, waitrequest behaviour normal.

Source files
------------

// File: rtl/mips_bus_ram_if.sv
// rtl/mips_bus_ram_if.sv - Avalon-style mips_cpu_bus port bundle for mips_bus_ram
//
// Master drives:  address[31:0], read, write, byteenable[3:0], writedata[31:0]
// Slave drives:   waitrequest, readdata[31:0], readdatavalid,
//                 bus_error, err_address[31:0], n_reads[31:0], n_writes[31:0]
interface mips_bus_ram_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        bus_error;
    logic [31:0] err_address;
    logic [31:0] n_reads;
    logic [31:0] n_writes;

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata, readdatavalid,
               bus_error, err_address, n_reads, n_writes
    );

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid,
               bus_error, err_address, n_reads, n_writes
    );
endinterface

// File: rtl/mips_bus_ram.sv
// rtl/mips_bus_ram.sv - two-region (data/instruction) memory slave with stalls and error tracking
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high
//   bus    - mips_bus_ram_if.slave (address/read/write/byteenable/writedata in;
//            waitrequest/readdata/readdatavalid/bus_error/err_address/n_reads/n_writes out)
// Optional: define BUS_RAM_RANDOM_WAIT_EN to make each transfer's stall
//           length lfsr[3:0] & WAIT_CYCLES instead of a fixed WAIT_CYCLES.
module mips_bus_ram #(
    parameter logic [31:0] DATA_BASE   = 32'h0000_0000,
    parameter int          DATA_WORDS  = 64,
    parameter logic [31:0] INSTR_BASE  = 32'hBFC0_0000,
    parameter int          INSTR_WORDS = 256,
    parameter int          WAIT_CYCLES = 0,
    parameter string       DATA_INIT   = "",
    parameter string       INSTR_INIT  = ""
) (
    input  logic            clk,
    input  logic            reset,
    mips_bus_ram_if.slave   bus
);
    localparam int DAW = (DATA_WORDS  > 1) ? $clog2(DATA_WORDS)  : 1;
    localparam int IAW = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;
    localparam logic [32:0] DATA_BYTES  = 33'(DATA_WORDS)  * 33'd4;
    localparam logic [32:0] INSTR_BYTES = 33'(INSTR_WORDS) * 33'd4;
    localparam logic [3:0]  WAIT4       = 4'(WAIT_CYCLES);

    typedef enum logic {S_IDLE, S_STALL} state_t;

    logic [31:0] data_mem  [DATA_WORDS];
    logic [31:0] instr_mem [INSTR_WORDS];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  wait_len;
    logic [31:0] readdata_q, readdata_d;
    logic        rdv_q, rdv_d;
    logic        bus_error_q, bus_error_d;
    logic [31:0] err_address_q, err_address_d;
    logic [31:0] n_reads_q, n_reads_d;
    logic [31:0] n_writes_q, n_writes_d;

    // Exact decode: offset computed from each base, hit only inside the window.
    logic [31:0]    data_off, instr_off;
    logic           data_hit, instr_hit;
    logic [DAW-1:0] data_idx;
    logic [IAW-1:0] instr_idx;
    logic [31:0]    mem_word, lane_mask;
    logic           req, waitreq, accept, legal, do_read, do_write, bad;

    assign data_off  = bus.address - DATA_BASE;
    assign instr_off = bus.address - INSTR_BASE;
    assign data_hit  = (bus.address >= DATA_BASE)  && ({1'b0, data_off}  < DATA_BYTES);
    assign instr_hit = (bus.address >= INSTR_BASE) && ({1'b0, instr_off} < INSTR_BYTES);
    assign data_idx  = data_off[DAW+1:2];
    assign instr_idx = instr_off[IAW+1:2];
    assign mem_word  = data_hit ? data_mem[data_idx] : instr_mem[instr_idx];
    assign lane_mask = {{8{bus.byteenable[3]}}, {8{bus.byteenable[2]}},
                        {8{bus.byteenable[1]}}, {8{bus.byteenable[0]}}};

    assign legal = (bus.address[1:0] == 2'b00) && (data_hit || instr_hit) &&
                   !(bus.read && bus.write) && (bus.byteenable != 4'h0);

    assign req      = bus.read | bus.write;
    assign waitreq  = req && (cnt_q != wait_len);
    assign accept   = req && !waitreq;
    assign do_read  = accept && legal && bus.read;
    assign do_write = accept && legal && bus.write;
    // Illegal requests still run through the stall and get accepted, only to be flagged.
    assign bad      = accept && !legal;

`ifdef BUS_RAM_RANDOM_WAIT_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci taps 16,14,13,11; stable for the whole transfer since it only
    // steps on acceptance.
    always_comb begin
        lfsr_d = lfsr_q;
        if (accept) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign wait_len = lfsr_q[3:0] & WAIT4;
`else
    assign wait_len = WAIT4;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        readdata_d    = readdata_q;
        rdv_d         = 1'b0;
        bus_error_d   = bus_error_q;
        err_address_d = err_address_q;
        n_reads_d     = n_reads_q;
        n_writes_d    = n_writes_q;

        case (state_q)
            S_IDLE: begin
                if (req && !accept) begin
                    state_d = S_STALL;
                    cnt_d   = 4'd1;
                end else begin
                    cnt_d   = 4'd0;
                end
            end
            S_STALL: begin
                // A dropped request abandons the stall without side effects.
                if (!req || accept) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        if (do_read) begin
            readdata_d = mem_word & lane_mask;
            rdv_d      = 1'b1;
            n_reads_d  = n_reads_q + 32'd1;
        end
        if (do_write) begin
            n_writes_d = n_writes_q + 32'd1;
        end
        if (bad) begin
            bus_error_d = 1'b1;
            if (!bus_error_q) begin
                err_address_d = bus.address;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 4'd0;
            readdata_q    <= 32'd0;
            rdv_q         <= 1'b0;
            bus_error_q   <= 1'b0;
            err_address_q <= 32'd0;
            n_reads_q     <= 32'd0;
            n_writes_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            readdata_q    <= readdata_d;
            rdv_q         <= rdv_d;
            bus_error_q   <= bus_error_d;
            err_address_q <= err_address_d;
            n_reads_q     <= n_reads_d;
            n_writes_q    <= n_writes_d;
        end
    end

    // Storage is not reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (do_write && !reset) begin
            for (int n = 0; n < 4; n++) begin
                if (bus.byteenable[n]) begin
                    if (data_hit) begin
                        data_mem[data_idx][8*n +: 8] <= bus.writedata[8*n +: 8];
                    end else begin
                        instr_mem[instr_idx][8*n +: 8] <= bus.writedata[8*n +: 8];
                    end
                end
            end
        end
    end

    assign bus.waitrequest   = waitreq;
    assign bus.readdata      = readdata_q;
    assign bus.readdatavalid = rdv_q;
    assign bus.bus_error     = bus_error_q;
    assign bus.err_address   = err_address_q;
    assign bus.n_reads       = n_reads_q;
    assign bus.n_writes      = n_writes_q;
endmodule
